// File: rtl/tim_apb_ctrl.sv
// APB slave front-end: turns APB setup/access phases into one-cycle register-block strobes.
// Latency: pready in the 2nd cycle of a transfer plus WAIT_CYCLES wait states.
// Backpressure: pready held low for WAIT_CYCLES; psel/penable drop during WAIT aborts the transfer.
// Optional: define TIM_APB_ADDR_CHECK_EN to reject misaligned or out-of-range (>0x01C) addresses with pslverr.
module tim_apb_ctrl #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        tim_psel,
  input  logic        tim_penable,
  input  logic        tim_pwrite,
  input  logic [11:0] tim_paddr,
  input  logic [31:0] tim_pwdata,
  input  logic [3:0]  tim_pstrb,
  output logic        tim_pready,
  output logic        tim_pslverr,
  output logic [31:0] tim_prdata,
  output logic        wr_en,
  output logic        rd_en,
  output logic [11:0] reg_paddr,
  output logic [31:0] reg_pwdata,
  output logic [3:0]  reg_pstrb,
  input  logic [31:0] reg_prdata,
  input  logic        reg_error_flag
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_wait_cnt;
  logic [11:0] r_paddr;
  logic [31:0] r_pwdata;
  logic [3:0]  r_pstrb;
  logic        r_write;
  logic        w_setup;
  logic        w_addr_err;

  // A setup phase is psel without penable; penable alone never starts a transfer.
  assign w_setup = tim_psel & ~tim_penable;

`ifdef TIM_APB_ADDR_CHECK_EN
  // Only word-aligned addresses inside the 8-register window are accepted.
  assign w_addr_err = (r_paddr[1:0] != 2'b00) || (r_paddr > 12'h01C);
`else
  assign w_addr_err = 1'b0;
`endif

  assign reg_paddr  = r_paddr;
  assign reg_pwdata = r_pwdata;
  assign reg_pstrb  = r_pstrb;

  // FSM state register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and outputs; all outputs decode from the registered state so reset clears them at once.
  always_comb begin
    w_state_nxt = r_state;
    tim_pready  = 1'b0;
    tim_pslverr = 1'b0;
    tim_prdata  = 32'h0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_setup) begin
          w_state_nxt = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        if (!tim_psel || !tim_penable) begin
          w_state_nxt = IDLE;
        end else if (r_wait_cnt <= 4'd1) begin
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        tim_pready  = 1'b1;
        w_state_nxt = IDLE;
        if (w_addr_err) begin
          tim_pslverr = 1'b1;
        end else if (r_write) begin
          wr_en       = 1'b1;
          tim_pslverr = reg_error_flag;
        end else begin
          rd_en       = 1'b1;
          tim_prdata  = reg_prdata;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Wait-state counter: loaded at setup, counts down while waiting.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wait_cnt <= 4'd0;
    end else if (r_state == IDLE && w_setup) begin
      r_wait_cnt <= LP_WAIT;
    end else if (r_state == WAIT && r_wait_cnt != 4'd0) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

  // Transfer attributes are captured at setup and held until the next setup.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_paddr  <= 12'h0;
      r_pwdata <= 32'h0;
      r_pstrb  <= 4'h0;
      r_write  <= 1'b0;
    end else if (r_state == IDLE && w_setup) begin
      r_paddr  <= tim_paddr;
      r_pwdata <= tim_pwdata;
      r_pstrb  <= tim_pstrb;
      r_write  <= tim_pwrite;
    end
  end

endmodule

// File: tb/tb_tim_apb_ctrl.sv
// Directed bench for tim_apb_ctrl: three instances with WAIT_CYCLES = 0, 3, 4.
// Each instance has its own psel; all other APB inputs are shared.
// Inputs change 1 time unit after the rising edge; outputs sampled 1 unit later.
module tb_tim_apb_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [2:0]  sel = 3'b000;
  logic        pen = 1'b0;
  logic        pwrite = 1'b0;
  logic [11:0] paddr = 12'h0;
  logic [31:0] pwdata = 32'h0;
  logic [3:0]  pstrb = 4'h0;
  logic [31:0] rdat_in = 32'h0;
  logic        err_mode = 1'b0;

  wire  [2:0]  pready;
  wire  [2:0]  pslverr;
  wire  [2:0]  wr_en;
  wire  [2:0]  rd_en;
  wire  [2:0]  err_flag;
  wire  [31:0] prdata [3];
  wire  [11:0] rpaddr [3];
  wire  [31:0] rpwdata [3];
  wire  [3:0]  rpstrb [3];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Register block model: write rejection follows wr_en combinationally.
  assign err_flag = wr_en & {3{err_mode}};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    tim_apb_ctrl #(.WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 3 : 4))) u_dut (
      .sys_clk       (sys_clk),
      .sys_rst       (sys_rst),
      .tim_psel      (sel[g]),
      .tim_penable   (pen),
      .tim_pwrite    (pwrite),
      .tim_paddr     (paddr),
      .tim_pwdata    (pwdata),
      .tim_pstrb     (pstrb),
      .tim_pready    (pready[g]),
      .tim_pslverr   (pslverr[g]),
      .tim_prdata    (prdata[g]),
      .wr_en         (wr_en[g]),
      .rd_en         (rd_en[g]),
      .reg_paddr     (rpaddr[g]),
      .reg_pwdata    (rpwdata[g]),
      .reg_pstrb     (rpstrb[g]),
      .reg_prdata    (rdat_in),
      .reg_error_flag(err_flag[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs a full transfer on instance d; returns once the cycle after pready has begun.
  task automatic xfer(input int d, input logic wr, input logic [11:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output int nwait, output logic [31:0] rd_o,
                      output logic err_o, output int nwr, output int nrd, output logic done);
    nwait = 0; nwr = 0; nrd = 0; done = 1'b0; rd_o = 32'hx; err_o = 1'bx;
    sel = 3'b000; sel[d] = 1'b1;
    pen = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    #1;
    if (wr_en[d]) nwr++;
    if (rd_en[d]) nrd++;
    @(posedge sys_clk); #1;
    pen = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      if (wr_en[d]) nwr++;
      if (rd_en[d]) nrd++;
      if (pready[d]) begin
        done  = 1'b1;
        rd_o  = prdata[d];
        err_o = pslverr[d];
      end else begin
        nwait++;
      end
      @(posedge sys_clk); #1;
    end
  endtask

  // Holds current inputs for n cycles, counting any pready or strobe on instance d.
  task automatic watch(input int d, input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      #1;
      if (pready[d] || wr_en[d] || rd_en[d]) cnt++;
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic bus_idle();
    sel = 3'b000;
    pen = 1'b0;
  endtask

  int          nw, nwr, nrd, cnt, c0;
  logic [31:0] rd;
  logic        er, dn;

  initial begin
    // Reset state
    #1 sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_pready0", {29'h0, pready}, 32'h0);
    check("rst_strobes", {26'h0, wr_en, rd_en}, 32'h0);
    check("rst_pslverr", {29'h0, pslverr}, 32'h0);
    check("rst_prdata1", prdata[1], 32'h0);
    check("rst_regaddr0", {20'h0, rpaddr[0]}, 32'h0);
    check("rst_regwdata2", rpwdata[2], 32'h0);
    check("rst_regstrb0", {28'h0, rpstrb[0]}, 32'h0);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    // Zero-wait write: pready in the 2nd cycle
    xfer(0, 1'b1, 12'h000, 32'h0000_0103, 4'hF, nw, rd, er, nwr, nrd, dn);
    check("w0_done", {31'h0, dn}, 32'h1);
    check("w0_waits", nw, 0);
    check("w0_wr_pulses", nwr, 1);
    check("w0_rd_pulses", nrd, 0);
    check("w0_pslverr", {31'h0, er}, 32'h0);
    check("w0_prdata_on_write", rd, 32'h0);
    check("w0_reg_pwdata", rpwdata[0], 32'h0000_0103);
    check("w0_reg_pstrb", {28'h0, rpstrb[0]}, 32'hF);
    bus_idle();
    #1;
    check("w0_after_pready", {31'h0, pready[0]}, 32'h0);
    @(posedge sys_clk); #1;

    // Three-wait read; strobes are latched on reads too
    rdat_in = 32'hFFFF_FFFF;
    xfer(1, 1'b0, 12'h00C, 32'h1234_5678, 4'h5, nw, rd, er, nwr, nrd, dn);
    check("r3_waits", nw, 3);
    check("r3_prdata", rd, 32'hFFFF_FFFF);
    check("r3_rd_pulses", nrd, 1);
    check("r3_wr_pulses", nwr, 0);
    check("r3_pslverr", {31'h0, er}, 32'h0);
    check("r3_reg_paddr", {20'h0, rpaddr[1]}, 32'h00C);
    check("r3_reg_pstrb", {28'h0, rpstrb[1]}, 32'h5);
    bus_idle();
    #1;
    check("r3_prdata_idle", prdata[1], 32'h0);
    @(posedge sys_clk); #1;

    // Back-to-back reads on the three-wait instance: 2+3 cycles each
    c0 = cyc;
    rdat_in = 32'hA5A5_0001;
    xfer(1, 1'b0, 12'h010, 32'h0, 4'h0, nw, rd, er, nwr, nrd, dn);
    check("b2b_first_prdata", rd, 32'hA5A5_0001);
    rdat_in = 32'h5A5A_0002;
    xfer(1, 1'b0, 12'h014, 32'h0, 4'h0, nw, rd, er, nwr, nrd, dn);
    check("b2b_second_prdata", rd, 32'h5A5A_0002);
    check("b2b_second_waits", nw, 3);
    check("b2b_cycles", cyc - c0, 10);
    bus_idle();
    @(posedge sys_clk); #1;

    // Write rejected by the register block
    err_mode = 1'b1;
    xfer(0, 1'b1, 12'h004, 32'hDEAD_BEEF, 4'h3, nw, rd, er, nwr, nrd, dn);
    check("err_pslverr", {31'h0, er}, 32'h1);
    check("err_wr_pulses", nwr, 1);
    err_mode = 1'b0;
    bus_idle();
    @(posedge sys_clk); #1;

    // penable without a setup phase is ignored
    sel[0] = 1'b1; pen = 1'b1; pwrite = 1'b1; paddr = 12'h008;
    watch(0, 3, cnt);
    check("noset_events", cnt, 0);
    bus_idle();
    @(posedge sys_clk); #1;

    // Four-wait write aborted by dropping psel in the 2nd wait cycle
    sel[2] = 1'b1; pen = 1'b0; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'h0BAD_0BAD; pstrb = 4'hF;
    @(posedge sys_clk); #1;
    pen = 1'b1;
    watch(2, 1, cnt);
    sel[2] = 1'b0;
    watch(2, 8, nw);
    check("abort_events", cnt + nw, 0);
    bus_idle();
    xfer(2, 1'b1, 12'h018, 32'h0000_0777, 4'hF, nw, rd, er, nwr, nrd, dn);
    check("post_abort_waits", nw, 4);
    check("post_abort_wr_pulses", nwr, 1);
    check("post_abort_pslverr", {31'h0, er}, 32'h0);
    bus_idle();
    @(posedge sys_clk); #1;

    // Address range/alignment behaviour, with 0x01C as the last valid word
    xfer(0, 1'b1, 12'h020, 32'h1111_1111, 4'hF, nw, rd, er, nwr, nrd, dn);
`ifdef TIM_APB_ADDR_CHECK_EN
    check("addr020_pslverr", {31'h0, er}, 32'h1);
    check("addr020_wr_pulses", nwr, 0);
`else
    check("addr020_pslverr", {31'h0, er}, 32'h0);
    check("addr020_wr_pulses", nwr, 1);
`endif
    xfer(0, 1'b1, 12'h006, 32'h2222_2222, 4'hF, nw, rd, er, nwr, nrd, dn);
`ifdef TIM_APB_ADDR_CHECK_EN
    check("addr006_pslverr", {31'h0, er}, 32'h1);
    check("addr006_wr_pulses", nwr, 0);
`else
    check("addr006_pslverr", {31'h0, er}, 32'h0);
    check("addr006_wr_pulses", nwr, 1);
`endif
    check("addr006_done", {31'h0, dn}, 32'h1);
    xfer(0, 1'b1, 12'h01C, 32'h3333_3333, 4'hF, nw, rd, er, nwr, nrd, dn);
    check("addr01c_wr_pulses", nwr, 1);
    check("addr01c_pslverr", {31'h0, er}, 32'h0);
    check("addr01c_reg_paddr", {20'h0, rpaddr[0]}, 32'h01C);
    bus_idle();
    @(posedge sys_clk); #1;

    // Reset asserted during WAIT
    sel[2] = 1'b1; pen = 1'b0; pwrite = 1'b1; paddr = 12'h014; pwdata = 32'hCAFE_0014; pstrb = 4'hF;
    @(posedge sys_clk); #1;
    pen = 1'b1;
    #1;
    check("rstw_latched_addr", {20'h0, rpaddr[2]}, 32'h014);
    sys_rst = 1'b1;
    #1;
    check("rstw_reg_paddr", {20'h0, rpaddr[2]}, 32'h0);
    check("rstw_reg_pwdata", rpwdata[2], 32'h0);
    check("rstw_reg_pstrb", {28'h0, rpstrb[2]}, 32'h0);
    check("rstw_other_reg_paddr", {20'h0, rpaddr[0]}, 32'h0);
    check("rstw_outputs", {pready, pslverr, wr_en, rd_en}, 32'h0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    watch(2, 3, cnt);
    check("rstw_release_events", cnt, 0);
    bus_idle();
    @(posedge sys_clk); #1;
    xfer(2, 1'b1, 12'h014, 32'hCAFE_0014, 4'hF, nw, rd, er, nwr, nrd, dn);
    check("rstw_retry_waits", nw, 4);
    check("rstw_retry_wr_pulses", nwr, 1);
    check("rstw_retry_reg_pwdata", rpwdata[2], 32'hCAFE_0014);
    bus_idle();
    @(posedge sys_clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
